// File: rtl/conv_17_if.sv
// rtl/conv_17_if.sv - pixel stream bundle between conv_71 and conv_17
//
// Signals:
//   pxl_in     8  unsigned input pixel from the vertical stage
//   in_valid   1  input qualifier
//   pxl_out    8  filtered pixel
//   valid      1  pxl_out is meaningful this cycle
//   row_end    1  last valid pixel of an output row
//   frame_end  1  last valid pixel of an output frame
// Modports: master drives the input side, slave is the filter.
interface conv_17_if;
    logic [7:0] pxl_in;
    logic       in_valid;
    logic [7:0] pxl_out;
    logic       valid;
    logic       row_end;
    logic       frame_end;

    modport master (
        output pxl_in, in_valid,
        input  pxl_out, valid, row_end, frame_end
    );

    modport slave (
        input  pxl_in, in_valid,
        output pxl_out, valid, row_end, frame_end
    );
endinterface

// File: rtl/conv_17.sv
// rtl/conv_17.sv - horizontal 7-tap binomial filter [1 6 15 20 15 6 1]/64
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    conv_17_if.slave: pxl_in/in_valid in, pxl_out/valid/row_end/frame_end out
// Parameters: W pixels per row, H rows per frame.
// Build option: define CONV17_ROUND_EN for round-half-up, otherwise truncate.
// Pipeline: S0 window register, S1 symmetric pair products, S2 final sum and
// output register; valid follows the sampling edge of the completing pixel by 2.
module conv_17 #(
    parameter int W = 220,
    parameter int H = 214
) (
    input  logic     clk,
    input  logic     reset,
    conv_17_if.slave bus
);
    localparam int CW = $clog2(W);
    localparam int RW = $clog2(H);

    logic [CW-1:0]   r_col;
    logic [RW-1:0]   r_row;
    logic [6:0][7:0] r_win;
    logic            r_s0_valid;
    logic            r_s0_row_end;
    logic            r_s0_frame_end;

    logic [13:0]     r_t0;
    logic [13:0]     r_t1;
    logic [13:0]     r_t2;
    logic [13:0]     r_t3;
    logic            r_s1_valid;
    logic            r_s1_row_end;
    logic            r_s1_frame_end;

    logic [7:0]      r_pxl_out;
    logic            r_valid;
    logic            r_row_end;
    logic            r_frame_end;

    logic            w_col_last;
    logic            w_row_last;
    logic            w_win_full;
    logic [8:0]      w_pair0;
    logic [8:0]      w_pair1;
    logic [8:0]      w_pair2;
    logic [13:0]     w_sum;
    logic [13:0]     w_sum_rnd;
    logic [7:0]      w_res;

    assign w_col_last = (r_col == CW'(W - 1));
    assign w_row_last = (r_row == RW'(H - 1));
    // The first six pixels of a row only prime the window, so no output ever
    // mixes pixels from two rows.
    assign w_win_full = (r_col >= CW'(6));

    // S0: window, position counters and per-pixel tags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_col          <= '0;
            r_row          <= '0;
            r_win          <= '0;
            r_s0_valid     <= 1'b0;
            r_s0_row_end   <= 1'b0;
            r_s0_frame_end <= 1'b0;
        end else begin
            r_s0_valid     <= 1'b0;
            r_s0_row_end   <= 1'b0;
            r_s0_frame_end <= 1'b0;
            if (bus.in_valid) begin
                r_win          <= {r_win[5:0], bus.pxl_in};
                r_s0_valid     <= w_win_full;
                r_s0_row_end   <= w_col_last;
                r_s0_frame_end <= w_col_last && w_row_last;
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
        end
    end

    // Kernel symmetry: fold mirrored taps before multiplying.
    assign w_pair0 = {1'b0, r_win[0]} + {1'b0, r_win[6]};
    assign w_pair1 = {1'b0, r_win[1]} + {1'b0, r_win[5]};
    assign w_pair2 = {1'b0, r_win[2]} + {1'b0, r_win[4]};

    // S2 sum; max 255*64 = 16320 fits 14 bits even after the +32.
    assign w_sum = r_t0 + r_t1 + r_t2 + r_t3;
`ifdef CONV17_ROUND_EN
    assign w_sum_rnd = w_sum + 14'd32;
`else
    assign w_sum_rnd = w_sum;
`endif
    assign w_res = 8'(w_sum_rnd >> 6);

    // S1 and S2 run every cycle; the valid bit rides along as a tag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_t0           <= '0;
            r_t1           <= '0;
            r_t2           <= '0;
            r_t3           <= '0;
            r_s1_valid     <= 1'b0;
            r_s1_row_end   <= 1'b0;
            r_s1_frame_end <= 1'b0;
            r_pxl_out      <= '0;
            r_valid        <= 1'b0;
            r_row_end      <= 1'b0;
            r_frame_end    <= 1'b0;
        end else begin
            r_t0           <= 14'(w_pair0);
            r_t1           <= 14'(w_pair1) * 14'd6;
            r_t2           <= 14'(w_pair2) * 14'd15;
            r_t3           <= 14'(r_win[3]) * 14'd20;
            r_s1_valid     <= r_s0_valid;
            r_s1_row_end   <= r_s0_valid && r_s0_row_end;
            r_s1_frame_end <= r_s0_valid && r_s0_frame_end;
            r_pxl_out      <= w_res;
            r_valid        <= r_s1_valid;
            r_row_end      <= r_s1_row_end;
            r_frame_end    <= r_s1_frame_end;
        end
    end

    assign bus.pxl_out   = r_pxl_out;
    assign bus.valid     = r_valid;
    assign bus.row_end   = r_row_end;
    assign bus.frame_end = r_frame_end;
endmodule

// File: tb/tb_conv_17.sv
// tb/tb_conv_17.sv - directed bench for conv_17
module tb_conv_17;
    localparam int W    = 220;
    localparam int H    = 214;
    localparam int NROW = W - 6;
    localparam int NFRM = H * (W - 6);

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    conv_17_if u_if ();
    conv_17 #(.W(W), .H(H)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int orphan = 0;
    int last_sample = 0;

    int q_pix[$];
    int q_re[$];
    int q_fe[$];
    int q_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (u_if.valid === 1'b1) begin
            q_pix.push_back(int'(u_if.pxl_out));
            q_re.push_back(int'(u_if.row_end));
            q_fe.push_back(int'(u_if.frame_end));
            q_cyc.push_back(cyc);
        end else if (u_if.row_end === 1'b1 || u_if.frame_end === 1'b1) begin
            orphan++;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input int p, input bit v);
        @(negedge clk);
        u_if.pxl_in   = 8'(p);
        u_if.in_valid = v;
        if (v) last_sample = cyc + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 1'b0);
    endtask

    task automatic clear_q;
        q_pix.delete();
        q_re.delete();
        q_fe.delete();
        q_cyc.delete();
    endtask

    // Checks one impulse row: 7 hand-computed taps at j=4..10, zero elsewhere.
    task automatic check_impulse(input string tag, input int e0, input int e1,
                                 input int e2, input int e3, input int e4,
                                 input int e5, input int e6);
        int exp_tab[7];
        int bad;
        int n;
        exp_tab = '{e0, e1, e2, e3, e4, e5, e6};
        bad = 0;
        check({tag, "_count"}, q_pix.size(), NROW);
        n = (q_pix.size() < NROW) ? q_pix.size() : NROW;
        for (int j = 0; j < n; j++) begin
            if (j >= 4 && j <= 10)
                check($sformatf("%s_j%0d", tag, j), q_pix[j], exp_tab[j-4]);
            else if (q_pix[j] != 0)
                bad++;
        end
        check({tag, "_zero_bad"}, bad, 0);
    endtask

    initial begin
        int bad_val;
        int bad_re;
        int bad_fe;
        int n_re;
        int n_fe;
        int seventh;
        int hold_bad;

        u_if.pxl_in   = '0;
        u_if.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pxl_out",   int'(u_if.pxl_out),   0);
        check("rst_valid",     int'(u_if.valid),     0);
        check("rst_row_end",   int'(u_if.row_end),   0);
        check("rst_frame_end", int'(u_if.frame_end), 0);
        reset = 1'b1;

        // Five rows plus row 5 columns 0..100, then an asynchronous reset.
        clear_q();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < W; c++) drive(77, 1'b1);
        for (int c = 0; c <= 100; c++) drive(77, 1'b1);
        @(posedge clk);
        #1;
        check("pre_rst_valid", int'(u_if.valid),   1);
        check("pre_rst_pxl",   int'(u_if.pxl_out), 77);
        check("pre_rst_count", q_pix.size(), 5 * NROW + 92);
        bad_val = 0;
        foreach (q_pix[i]) if (q_pix[i] != 77) bad_val++;
        check("pre_rst_val_bad", bad_val, 0);
        #1 reset = 1'b0;
        #1;
        check("async_rst_pxl",   int'(u_if.pxl_out), 0);
        check("async_rst_valid", int'(u_if.valid),   0);
        u_if.in_valid = 1'b1;
        u_if.pxl_in   = 8'd200;
        hold_bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (u_if.valid !== 1'b0) hold_bad++;
        end
        check("rst_ignores_input", hold_bad, 0);
        u_if.in_valid = 1'b0;
        reset = 1'b1;

        // Ramp row restarts at row 0, then the rest of the frame is constant 100.
        clear_q();
        for (int c = 0; c < W; c++) drive(c, 1'b1);
        for (int r = 1; r < H; r++)
            for (int c = 0; c < W; c++) drive(100, 1'b1);
        idle(5);
        check("frame_count", q_pix.size(), NFRM);
        bad_val = 0; bad_re = 0; bad_fe = 0; n_re = 0; n_fe = 0;
        foreach (q_pix[i]) begin
            if (q_pix[i] != ((i < NROW) ? i + 3 : 100)) bad_val++;
            if (q_re[i] != ((i % NROW) == NROW - 1 ? 1 : 0)) bad_re++;
            if (q_fe[i] != ((i == NFRM - 1) ? 1 : 0)) bad_fe++;
            n_re += q_re[i];
            n_fe += q_fe[i];
        end
        check("frame_val_bad",   bad_val, 0);
        check("frame_row_end_n", n_re, H);
        check("frame_row_end_pos_bad", bad_re, 0);
        check("frame_end_n",     n_fe, 1);
        check("frame_end_pos_bad", bad_fe, 0);
        if (q_pix.size() >= NROW) begin
            check("ramp_first",  q_pix[0], 3);
            check("ramp_second", q_pix[1], 4);
            check("ramp_last",   q_pix[NROW-1], NROW - 1 + 3);
            check("ramp_b2b_span", q_cyc[NROW-1] - q_cyc[0], NROW - 1);
        end else begin
            check("ramp_outputs_present", q_pix.size(), NROW);
        end

        // Impulse of 64 at column 10 (row 0 of the next frame).
        clear_q();
        for (int c = 0; c < W; c++) drive((c == 10) ? 64 : 0, 1'b1);
        idle(5);
        check_impulse("imp64", 1, 6, 15, 20, 15, 6, 1);

        // Impulse of 32 at column 10.
        clear_q();
        for (int c = 0; c < W; c++) drive((c == 10) ? 32 : 0, 1'b1);
        idle(5);
`ifdef CONV17_ROUND_EN
        check_impulse("imp32", 1, 3, 8, 10, 8, 3, 1);
`else
        check_impulse("imp32", 0, 3, 7, 10, 7, 3, 0);
`endif

        // All-255 row with in_valid pattern 1,0,0.
        clear_q();
        seventh = 0;
        for (int c = 0; c < W; c++) begin
            drive(255, 1'b1);
            if (c == 6) seventh = last_sample;
            idle(2);
        end
        idle(5);
        check("gap_count", q_pix.size(), NROW);
        bad_val = 0; n_re = 0; n_fe = 0;
        foreach (q_pix[i]) begin
            if (q_pix[i] != 255) bad_val++;
            n_re += q_re[i];
            n_fe += q_fe[i];
        end
        check("gap_val_bad", bad_val, 0);
        check("gap_row_end_n", n_re, 1);
        check("gap_frame_end_n", n_fe, 0);
        if (q_pix.size() > 0) begin
            check("gap_first_latency", q_cyc[0] - seventh, 2);
            check("gap_row_end_last", q_re[q_re.size()-1], 1);
        end else begin
            check("gap_outputs_present", 0, NROW);
        end

        check("orphan_tags", orphan, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_17.md
# conv_17

Horizontal 7-tap binomial filter stage that sits directly downstream of the 7x1 vertical convolution (`conv_71`) and completes the separable 7x7 smoothing of a raster-scanned 8-bit image. It consumes the vertically filtered pixel stream and its `valid` qualifier. Per row, it keeps a 7-pixel window and emits one filtered pixel for every fully populated window. It also generates row-end and frame-end markers for the next stage.

## Interface
- `W`, 220, pixels per input row.
- `H`, 214, rows per input frame (the row count delivered by the 7x1 stage).
- `clk`  input  1  single clock; all state updates on its rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `pxl_in`  input  8  unsigned input pixel; sampled only when `in_valid`=1.
- `in_valid`  input  1  input qualifier; driven by the upstream `valid`.
- `pxl_out`  output  8  filtered pixel, unsigned.
- `valid`  output  1  `pxl_out` is meaningful this cycle.
- `row_end`  output  1  high together with the last `valid` pixel of an output row.
- `frame_end`  output  1  high together with the last `valid` pixel of an output frame.

## Operation
- Window and kernel:
  - Kernel is [1 6 15 20 15 6 1] with a normaliser of 64.
  - Tap 0 is the newest sample.
- Counters:
  - `col` counts accepted pixels 0..W-1 and wraps to 0 after W-1.
  - `row` counts 0..H-1. It increments when `col` wraps and wraps to 0 after H-1.
  - Both counters advance only on `in_valid`=1.
- Window shift:
  - On `in_valid`=1, the 7-entry shift register shifts and loads `pxl_in`.
  - On `in_valid`=0, the window holds.
- Output generation:
  - A window is complete when the accepted pixel has `col`>=6.
  - Each row therefore yields W-6 outputs (214 for the defaults), and a frame yields H*(W-6) = 45796.
  - Output j of a row equals filter(in[j..j+6]), i.e. it is centred on input column j+3.
  - Windows never span two rows, because the `col`>=6 gate discards the first 6 pixels of each row.
- Arithmetic:
  - Products are exact.
  - The sum is 14 bits wide; the maximum is 255*64 = 16320.
  - Result = (sum + 32) >> 6 with `CONV17_ROUND_EN`, otherwise sum >> 6.
  - The result is always <=255, so no saturation logic is needed.
- Markers:
  - `row_end` is tagged when the accepted pixel has `col`=W-1.
  - `frame_end` is tagged when, in addition, `row`=H-1.
  - Tags travel down the pipeline aligned with their pixel.
- `in_valid` gaps of any length are allowed. Output order and values are independent of gap pattern.

## Timing
- Pipeline structure:
  - S0: window register.
  - S1: registered symmetric pair sums and products (4 partial terms).
  - S2: registered final sum, rounding, and outputs.
- Latency: `valid` rises exactly 2 cycles after the edge that samples the completing pixel. Example: pixel sampled at edge k → `valid` high after edge k+2.
- S1 and S2 advance every cycle, independent of `in_valid`; the valid bit flows as a pipeline tag.
- Throughput is one output per cycle for back-to-back input.
- `valid`, `row_end` and `frame_end` are single-cycle per pixel. They are never high without `valid`.
- Reset (`reset`=0, asynchronous) clears the following immediately, without waiting for a clock edge:
  - `pxl_out`=0, `valid`=0, `row_end`=0, `frame_end`=0.
  - Window, pipeline, `col` and `row` all to 0.
- Reset mid-row or mid-frame discards all in-flight data. The first accepted pixel after release is treated as column 0, row 0.
- `in_valid` is ignored while `reset`=0.

## Configuration
- `CONV17_ROUND_EN` defined: round-half-up, i.e. add 32 before the >>6.
- `CONV17_ROUND_EN` undefined: truncate, i.e. plain >>6. No adder is instantiated.

## Test plan
- Constant 100 for a full frame, `in_valid` continuous → every output is 100; exactly 214 `valid` per row; `row_end` 214 times; one `frame_end` on output 45796.
- Row of zeros with 64 at column 10 → outputs j=4..10 are 1,6,15,20,15,6,1; all other outputs 0.
- Row of zeros with 32 at column 10 → outputs j=4..10 are 1,3,8,10,8,3,1 with `CONV17_ROUND_EN`, and 0,3,7,10,7,3,0 without it.
- All-255 row with `in_valid` toggling 1,0,0,1… → every output 255, same count and order as the continuous case; first `valid` exactly 2 cycles after the 7th accepted pixel.
- Assert `reset`=0 after column 100 of row 5 → all outputs 0 within the same cycle; after release, a ramp row 0..219 gives first output 3, then 4, ... (integer ramp reproduces the centre value); `row`/`col` restarted from 0.
- 220 pixels with the row counter at H-1 → `frame_end` and `row_end` both high on output j=213 only; next accepted pixel starts row 0.
